// File: rtl/cam_pkg.sv
// Shared camera stream types: region state, RGB565 bar colours and default
// OV7670-style VGA timing, also used by the capture block's bench.
package cam_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, BACK, ACTIVE, FRONT} cam_state_e;

    localparam int CAM_H_ACTIVE    = 640;
    localparam int CAM_V_ACTIVE    = 480;
    localparam int CAM_H_BLANK     = 144;
    localparam int CAM_VSYNC_LINES = 3;
    localparam int CAM_V_BACK      = 17;
    localparam int CAM_V_FRONT     = 10;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic cam_state_e region(int v, int vs, int vb, int va);
        if (v < vs)           return VSYNC;
        if (v < vs + vb)      return BACK;
        if (v < vs + vb + va) return ACTIVE;
        return FRONT;
    endfunction

    function automatic logic [15:0] bar_color(logic [2:0] bar);
        case (bar)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_timing_counter.sv
// Frame position counters and region FSM; exposes next-cycle position so the
// stream outputs can be registered and still line up with the counters.
module cam_timing_counter
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = CAM_H_ACTIVE,
    parameter int V_ACTIVE    = CAM_V_ACTIVE,
    parameter int H_BLANK     = CAM_H_BLANK,
    parameter int VSYNC_LINES = CAM_VSYNC_LINES,
    parameter int V_BACK      = CAM_V_BACK,
    parameter int V_FRONT     = CAM_V_FRONT,
    localparam int H_TOTAL    = 2 * H_ACTIVE + H_BLANK,
    localparam int V_TOTAL    = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT,
    localparam int HW         = $clog2(H_TOTAL),
    localparam int VW         = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    output cam_state_e    state_nxt_o,
    output logic [HW-1:0] h_nxt_o,
    output logic [VW-1:0] v_nxt_o,
    output logic          frame_done_o
);

    cam_state_e    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          frame_done_q, frame_done_d;
    logic          h_last, v_last;

    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == IDLE) begin
            h_d = '0;
            v_d = '0;
            if (enable_i) state_d = VSYNC;
        end else begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // enable only matters on the frame wrap, so a frame is never cut short
            if (h_last && v_last) state_d = enable_i ? VSYNC : IDLE;
            else                  state_d = region(int'(v_d), VSYNC_LINES, V_BACK, V_ACTIVE);
        end
        frame_done_d = (state_d != IDLE) && (h_d == HW'(H_TOTAL - 1)) &&
                       (v_d == VW'(V_TOTAL - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            h_q          <= '0;
            v_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign state_nxt_o  = state_d;
    assign h_nxt_o      = h_d;
    assign v_nxt_o      = v_d;
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style camera emulator: frame buffer reads serialised as RGB565 bytes.
// Define TEST_PATTERN_EN to replace the frame buffer with 8 vertical colour bars.
module cam_stream_gen
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = CAM_H_ACTIVE,
    parameter int V_ACTIVE    = CAM_V_ACTIVE,
    parameter int H_BLANK     = CAM_H_BLANK,
    parameter int VSYNC_LINES = CAM_VSYNC_LINES,
    parameter int V_BACK      = CAM_V_BACK,
    parameter int V_FRONT     = CAM_V_FRONT
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        enable,
    output logic        rd_en,
    output logic [9:0]  rd_x,
    output logic [9:0]  rd_y,
    input  logic [15:0] pixel,
    output logic        cam_vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_done
);

    localparam int H_TOTAL = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    cam_state_e    state_n;
    logic [HW-1:0] h_n;
    logic [VW-1:0] v_n;

    logic       vsync_q, vsync_d, href_q, href_d, rd_en_q, rd_en_d;
    logic [7:0] data_q, data_d;
    logic [9:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;

    cam_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
    ) u_timing (
        .clk_i(pclk), .rst_i(reset), .enable_i(enable),
        .state_nxt_o(state_n), .h_nxt_o(h_n), .v_nxt_o(v_n),
        .frame_done_o(frame_done)
    );

    always_comb begin
        vsync_d = (state_n == VSYNC);
        href_d  = (state_n == ACTIVE) && (int'(h_n) < 2 * H_ACTIVE);
    end

`ifdef TEST_PATTERN_EN
    logic [15:0] bar_w;

    always_comb begin
        bar_w   = bar_color(3'((int'(h_n) / 2) * 8 / H_ACTIVE));
        rd_en_d = 1'b0;
        rd_x_d  = '0;
        rd_y_d  = '0;
        data_d  = '0;
        if (href_d) data_d = h_n[0] ? bar_w[7:0] : bar_w[15:8];
    end
`else
    logic [7:0] pix_lo_q;
    logic       rd_vld_q;
    int         h2, v2;

    // Read issues two positions ahead: the high byte goes straight from the
    // returning read data, so only the low byte needs to be held.
    always_comb begin
        h2 = int'(h_n) + 2;
        v2 = int'(v_n);
        if (h2 >= H_TOTAL) begin
            h2 = h2 - H_TOTAL;
            v2 = v2 + 1;
        end
        rd_en_d = (state_n != IDLE) && (v2 >= VSYNC_LINES + V_BACK) &&
                  (v2 < VSYNC_LINES + V_BACK + V_ACTIVE) &&
                  (h2 < 2 * H_ACTIVE) && ((h2 % 2) == 0);
        rd_x_d  = (state_n == IDLE) ? '0 : rd_x_q;
        rd_y_d  = (state_n == IDLE) ? '0 : rd_y_q;
        if (rd_en_d) begin
            rd_x_d = 10'(h2 / 2);
            rd_y_d = 10'(v2 - VSYNC_LINES - V_BACK);
        end
        data_d = '0;
        if (href_d) data_d = h_n[0] ? pix_lo_q : pixel[15:8];
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            pix_lo_q <= '0;
        end else begin
            rd_vld_q <= rd_en_q;
            if (rd_vld_q) pix_lo_q <= pixel[7:0];
        end
    end
`endif

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= '0;
            rd_en_q <= 1'b0;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            rd_en_q <= rd_en_d;
            rd_x_q  <= rd_x_d;
            rd_y_q  <= rd_y_d;
        end
    end

    assign cam_vsync = vsync_q;
    assign href      = href_q;
    assign data      = data_q;
    assign rd_en     = rd_en_q;
    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen with small timing; frame position k counts
// cycles from the first VSYNC cycle (k = 14*line_of_frame + h in memory mode).
module tb_cam_stream_gen;
`ifdef TEST_PATTERN_EN
    localparam int HA = 8;
`else
    localparam int HA = 4;
`endif
    localparam int VA = 3, HB = 6, VSL = 1, VB = 1, VF = 1;
    localparam int HT = 2 * HA + HB;
    localparam int VT = VSL + VB + VA + VF;
    localparam int FT = HT * VT;

    logic        pclk = 1'b0;
    logic        reset, enable;
    logic        rd_en, cam_vsync, href, frame_done;
    logic [9:0]  rd_x, rd_y;
    logic [15:0] pixel = 16'h0;
    logic [7:0]  data;

    int n_tests = 0;
    int n_fail  = 0;

    cam_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .pixel(pixel),
        .cam_vsync(cam_vsync), .href(href), .data(data), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    // Frame buffer model: one-cycle read latency, junk when not reading
    always @(posedge pclk) pixel <= rd_en ? {rd_y[5:0], rd_x} : 16'hDEAD;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".vsync"}, int'(cam_vsync), 0);
        check({tag, ".href"},  int'(href), 0);
        check({tag, ".data"},  int'(data), 0);
        check({tag, ".rd_en"}, int'(rd_en), 0);
        check({tag, ".rd_x"},  int'(rd_x), 0);
        check({tag, ".rd_y"},  int'(rd_y), 0);
        check({tag, ".fdone"}, int'(frame_done), 0);
    endtask

    typedef struct {
        int k, vs, hr, d, re, x, y, fd;
    } vec_t;
    typedef struct {
        int j, x, y;
    } rd_t;

    vec_t vecs[$];
    rd_t  rd_q[$];

    task automatic add(input int k, vs, hr, d, re, x, y, fd);
        vec_t v;
        v = '{k, vs, hr, d, re, x, y, fd};
        vecs.push_back(v);
    endtask

    initial begin
        int k, vs_cnt, hr_cnt, rd_cnt, fd_cnt, fd_pos, j;
        bit got;
        rd_t r;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b0;
        step();
        check_zero("idle");
        enable = 1'b1;
        step();

`ifdef TEST_PATTERN_EN
        begin
            int pat_exp[16] = '{'hFF, 'hFF, 'hFF, 'hE0, 'h07, 'hFF, 'h07, 'hE0,
                                'hF8, 'h1F, 'hF8, 'h00, 'h00, 'h1F, 'h00, 'h00};
            vs_cnt = 0; rd_cnt = 0; fd_pos = -1;
            for (int i = 0; i < FT; i++) begin
                if (cam_vsync)  vs_cnt++;
                if (rd_en)      rd_cnt++;
                if (frame_done) fd_pos = i;
                if (i >= 2 * HT && i < 2 * HT + 16) begin
                    check($sformatf("pat.href%0d", i - 2 * HT), int'(href), 1);
                    check($sformatf("pat.byte%0d", i - 2 * HT), int'(data), pat_exp[i - 2 * HT]);
                end
                step();
            end
            check("pat.rd_en_cnt", rd_cnt, 0);
            check("pat.vsync_cnt", vs_cnt, HT);
            check("pat.fdone_pos", fd_pos, FT - 1);
        end
`else
        // {k, vsync, href, data, rd_en, rd_x, rd_y, frame_done}
        add(0,  1, 0, 'h00, 0, 0, 0, 0);
        add(13, 1, 0, 'h00, 0, 0, 0, 0);
        add(14, 0, 0, 'h00, 0, 0, 0, 0);
        add(26, 0, 0, 'h00, 1, 0, 0, 0);
        add(27, 0, 0, 'h00, 0, 0, 0, 0);
        add(28, 0, 1, 'h00, 1, 1, 0, 0);
        add(29, 0, 1, 'h00, 0, 1, 0, 0);
        add(31, 0, 1, 'h01, 0, 2, 0, 0);
        add(42, 0, 1, 'h04, 1, 1, 1, 0);
        add(43, 0, 1, 'h00, 0, 1, 1, 0);
        add(49, 0, 1, 'h03, 0, 3, 1, 0);
        add(50, 0, 0, 'h00, 0, 3, 1, 0);
        add(58, 0, 1, 'h08, 1, 2, 2, 0);
        add(59, 0, 1, 'h01, 0, 2, 2, 0);
        add(70, 0, 0, 'h00, 0, 3, 2, 0);
        add(83, 0, 0, 'h00, 0, 3, 2, 1);
        add(84, 1, 0, 'h00, 0, 3, 2, 0);

        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin step(); k++; end
            check($sformatf("k%0d.vsync", k), int'(cam_vsync), vecs[i].vs);
            check($sformatf("k%0d.href", k),  int'(href), vecs[i].hr);
            check($sformatf("k%0d.data", k),  int'(data), vecs[i].d);
            check($sformatf("k%0d.rd_en", k), int'(rd_en), vecs[i].re);
            check($sformatf("k%0d.rd_x", k),  int'(rd_x), vecs[i].x);
            check($sformatf("k%0d.rd_y", k),  int'(rd_y), vecs[i].y);
            check($sformatf("k%0d.fdone", k), int'(frame_done), vecs[i].fd);
        end

        // Second frame: counts, read order and the two-cycle read lead
        vs_cnt = 0; hr_cnt = 0; rd_cnt = 0; fd_cnt = 0; fd_pos = -1;
        for (int i = 0; i < FT; i++) begin
            if (cam_vsync) vs_cnt++;
            if (href)      hr_cnt++;
            if (frame_done) begin fd_cnt++; fd_pos = i; end
            if (rd_q.size() > 0 && rd_q[0].j + 2 == i) begin
                r = rd_q.pop_front();
                check("lead.href", int'(href), 1);
                check("lead.data", int'(data), (r.y % 64) * 4 + r.x / 256);
            end
            if (rd_en) begin
                check("rd.x", int'(rd_x), rd_cnt % HA);
                check("rd.y", int'(rd_y), rd_cnt / HA);
                r = '{i, int'(rd_x), int'(rd_y)};
                rd_q.push_back(r);
                rd_cnt++;
            end
            step();
        end
        check("f2.vsync_cnt", vs_cnt, HT);
        check("f2.href_cnt", hr_cnt, 2 * HA * VA);
        check("f2.rd_cnt", rd_cnt, HA * VA);
        check("f2.fdone_cnt", fd_cnt, 1);
        check("f2.fdone_pos", fd_pos, FT - 1);

        // Drop enable mid-ACTIVE: frame must run to completion, then idle
        repeat (35) step();
        enable = 1'b0;
        j = 35; got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            if (frame_done) got = 1;
            else begin step(); j++; end
        end
        check("drop.fdone_pos", got ? j : -1, FT - 1);
        step();
        check_zero("drop.idle");
        repeat (5) step();
        check_zero("drop.idle5");
        enable = 1'b1;
        step();
        check("restart.vsync", int'(cam_vsync), 1);

        // Asynchronous reset mid-frame at k=40 (a read with rd_y=1 is live)
        repeat (40) step();
        #3 reset = 1'b1;
        #1 check_zero("async_rst");
        step();
        reset = 1'b0;
        step();
        vs_cnt = 0; fd_pos = -1; fd_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            if (cam_vsync) vs_cnt++;
            if (frame_done) begin fd_cnt++; fd_pos = i; end
            step();
        end
        check("rst.vsync_cnt", vs_cnt, HT);
        check("rst.fdone_cnt", fd_cnt, 1);
        check("rst.fdone_pos", fd_pos, FT - 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
